// File: rtl/regfile_multiport.sv
// Parametrised multi-port register file with a self-clearing sequencer.
// Reads are combinational; one synchronous write port with optional bypass.
module regfile_multiport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    writenable,
  input  logic [ADDR_W-1:0]       writesel,
  input  logic [DATA_W-1:0]       Din,
  input  logic [NREAD*ADDR_W-1:0] rs_sel,
  output logic [NREAD*DATA_W-1:0] rs_out,
  input  logic                    clr_req,
  output logic                    busy
);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH-1);
  localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

  state_t            state;
  state_t            state_n;
  logic [ADDR_W:0]   clr_ptr;
  logic [ADDR_W:0]   clr_ptr_n;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              ready;
  logic              wr_ok;
  logic              z_hit;

  assign ready = (state == READY);
  assign busy  = !ready;
  assign wr_ok = ready && writenable && !clr_req;
  assign z_hit = (ZERO_REG != 0) && (writesel == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_n;
      clr_ptr <= clr_ptr_n;
    end
  end

  always_comb begin
    state_n   = state;
    clr_ptr_n = clr_ptr;
    unique case (state)
      CLEAR: begin
        clr_ptr_n = clr_ptr + ONE;
        if (clr_ptr == LAST)
          state_n = READY;
      end
      READY: begin
        if (clr_req) begin
          state_n   = CLEAR;
          clr_ptr_n = '0;
        end
      end
      default: state_n = CLEAR;
    endcase
  end

  // Storage is never reset; the sequencer sweeps it instead.
  always_ff @(posedge clk) begin
    if (!ready)
      mem[clr_ptr[ADDR_W-1:0]] <= '0;
    else if (wr_ok && !z_hit)
      mem[writesel] <= Din;
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] sel;
    logic [DATA_W-1:0] rd;

    assign sel = rs_sel[k*ADDR_W +: ADDR_W];

    always_comb begin
      if (!ready || ((ZERO_REG != 0) && (sel == '0)))
        rd = '0;
      else if ((BYPASS != 0) && wr_ok && (sel == writesel))
        rd = Din;
      else
        rd = mem[sel];
    end

    assign rs_out[k*DATA_W +: DATA_W] = rd;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: three builds driven against
// an array model, plus directed literal expectations.
module tb_regfile_multiport;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we   [3];
  logic        clr  [3];
  logic [4:0]  ws   [3];
  logic [31:0] din  [3];
  logic [4:0]  rsel [3][4];
  logic        bz   [3];
  logic [63:0] ro0;
  logic [63:0] ro1;
  logic [63:0] ro2;

  int          npass = 0;
  int          ntot  = 0;
  int          cnt [3];
  logic [31:0] mm  [3][32];

  always #5 clk = ~clk;

  regfile_multiport dut0 (
    .clk        (clk),
    .rst        (rst),
    .writenable (we[0]),
    .writesel   (ws[0]),
    .Din        (din[0]),
    .rs_sel     ({rsel[0][1], rsel[0][0]}),
    .rs_out     (ro0),
    .clr_req    (clr[0]),
    .busy       (bz[0])
  );

  regfile_multiport #(
    .ZERO_REG (0),
    .BYPASS   (0)
  ) dut1 (
    .clk        (clk),
    .rst        (rst),
    .writenable (we[1]),
    .writesel   (ws[1]),
    .Din        (din[1]),
    .rs_sel     ({rsel[1][1], rsel[1][0]}),
    .rs_out     (ro1),
    .clr_req    (clr[1]),
    .busy       (bz[1])
  );

  regfile_multiport #(
    .DATA_W (16),
    .ADDR_W (3),
    .NREAD  (4)
  ) dut2 (
    .clk        (clk),
    .rst        (rst),
    .writenable (we[2]),
    .writesel   (ws[2][2:0]),
    .Din        (din[2][15:0]),
    .rs_sel     ({rsel[2][3][2:0], rsel[2][2][2:0],
                  rsel[2][1][2:0], rsel[2][0][2:0]}),
    .rs_out     (ro2),
    .clr_req    (clr[2]),
    .busy       (bz[2])
  );

  function automatic int aw(int i);
    return (i == 2) ? 3 : 5;
  endfunction

  function automatic int dpt(int i);
    return 1 << aw(i);
  endfunction

  function automatic int nr(int i);
    return (i == 2) ? 4 : 2;
  endfunction

  function automatic bit zr(int i);
    return i != 1;
  endfunction

  function automatic bit bp(int i);
    return i != 1;
  endfunction

  function automatic logic [31:0] dmask(int i);
    return (i == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] rd(int i, int k);
    if (i == 0) return ro0[k*32 +: 32];
    if (i == 1) return ro1[k*32 +: 32];
    return {16'h0, ro2[k*16 +: 16]};
  endfunction

  function automatic logic [31:0] exp_rd(int i, int k);
    logic [4:0] a;
    a = rsel[i][k];
    if (rst || cnt[i] > 0) return 32'h0;
    if (zr(i) && a == 5'd0) return 32'h0;
    if (bp(i) && we[i] && !clr[i] && a == ws[i])
      return din[i];
    return mm[i][a];
  endfunction

  function automatic void chk(string nm,
                              logic [31:0] act,
                              logic [31:0] exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endfunction

  // Model: a clear wipes the whole file at once and then
  // simply keeps the file unusable for DEPTH edges.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst || (cnt[i] == 0 && clr[i])) begin
        cnt[i] = dpt(i);
        for (int j = 0; j < 32; j++) mm[i][j] = 32'h0;
      end else if (cnt[i] > 0) begin
        cnt[i] = cnt[i] - 1;
      end else if (we[i] && !(zr(i) && ws[i] == 5'd0)) begin
        mm[i][ws[i]] = din[i];
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("busy%0d", i), 32'(bz[i]),
          32'(rst || cnt[i] > 0));
      for (int k = 0; k < nr(i); k++)
        chk($sformatf("rd%0d_%0d", i, k), rd(i, k), exp_rd(i, k));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic busy_len(string nm);
    int f [3];
    for (int i = 0; i < 3; i++) f[i] = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      for (int i = 0; i < 3; i++)
        if (f[i] < 0 && !bz[i]) f[i] = n;
    end
    chk({nm, "_len0"}, f[0], 32'd32);
    chk({nm, "_len1"}, f[1], 32'd32);
    chk({nm, "_len2"}, f[2], 32'd8);
  endtask

  task automatic set_wr(int i, logic w, logic [4:0] a,
                        logic [31:0] d);
    we[i]  = w;
    ws[i]  = a;
    din[i] = d;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      we[i]  = 1'b0;
      clr[i] = 1'b0;
      ws[i]  = '0;
      din[i] = '0;
      cnt[i] = dpt(i);
      for (int k = 0; k < 4; k++) rsel[i][k] = '0;
      for (int j = 0; j < 32; j++) mm[i][j] = '0;
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    busy_len("t1");

    for (int a = 0; a < 32; a++) begin
      rsel[0][0] = 5'(a);
      rsel[0][1] = 5'(31 - a);
      rsel[1][0] = 5'(a);
      #1;
      chk("t1_sweep0", rd(0, 0), 32'h0);
      chk("t1_sweep1", rd(1, 0), 32'h0);
      tick();
    end

    for (int i = 0; i < 2; i++) begin
      set_wr(i, 1'b1, 5'd1, 32'h8421);
      rsel[i][0] = 5'd1;
      rsel[i][1] = 5'd31;
    end
    #1;
    chk("t2_byp_p0", rd(0, 0), 32'h8421);
    chk("t2_byp_p1", rd(0, 1), 32'h0);
    chk("t2_nobyp", rd(1, 0), 32'h0);
    tick();
    we[0] = 1'b0;
    we[1] = 1'b0;
    #1;
    chk("t2_held0", rd(0, 0), 32'h8421);
    chk("t2_held1", rd(1, 0), 32'h8421);

    for (int i = 0; i < 2; i++) set_wr(i, 1'b1, 5'd0, 32'h1248);
    tick();
    for (int i = 0; i < 2; i++) begin
      we[i]      = 1'b0;
      rsel[i][0] = 5'd0;
      rsel[i][1] = 5'd1;
    end
    #1;
    chk("t3_r0_zero", rd(0, 0), 32'h0);
    chk("t3_r1", rd(0, 1), 32'h8421);
    chk("t3_r0_plain", rd(1, 0), 32'h1248);

    for (int i = 0; i < 2; i++) begin
      set_wr(i, 1'b1, 5'd5, 32'hDEAD);
      rsel[i][0] = 5'd5;
    end
    #1;
    chk("t4_old", rd(1, 0), 32'h0);
    chk("t4_byp", rd(0, 0), 32'hDEAD);
    tick();
    we[0] = 1'b0;
    we[1] = 1'b0;
    #1;
    chk("t4_new", rd(1, 0), 32'hDEAD);

    set_wr(0, 1'b1, 5'd2, 32'h77);
    clr[0]     = 1'b1;
    rsel[0][0] = 5'd2;
    rsel[0][1] = 5'd5;
    #1;
    chk("t5_busy_pre", 32'(bz[0]), 32'h0);
    chk("t5_no_byp", rd(0, 0), 32'h0);
    chk("t5_r5", rd(0, 1), 32'hDEAD);
    tick();
    we[0]  = 1'b0;
    clr[0] = 1'b0;
    #1;
    chk("t5_busy", 32'(bz[0]), 32'h1);
    chk("t5_rd_clr", rd(0, 1), 32'h0);
    repeat (9) tick();
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", 32'(bz[0]), 32'h1);
    tick();
    tick();
    rst = 1'b0;
    busy_len("t5");
    #1;
    chk("t5_r2", rd(0, 0), 32'h0);
    chk("t5_r5_clr", rd(0, 1), 32'h0);

    set_wr(2, 1'b1, 5'd6, 32'hBEEF);
    for (int k = 0; k < 4; k++) rsel[2][k] = 5'd6;
    #1;
    for (int k = 0; k < 4; k++) chk("t6_byp", rd(2, k), 32'hBEEF);
    tick();
    we[2] = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) chk("t6_held", rd(2, k), 32'hBEEF);
    tick();

    repeat (300) begin
      for (int i = 0; i < 3; i++) begin
        set_wr(i, 1'($urandom_range(0, 1)),
               5'($urandom_range(0, dpt(i) - 1)),
               $urandom & dmask(i));
        clr[i] = ($urandom_range(0, 39) == 0);
        for (int k = 0; k < 4; k++)
          rsel[i][k] = 5'($urandom_range(0, dpt(i) - 1));
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      we[i]  = 1'b0;
      clr[i] = 1'b0;
    end
    tick();
    tick();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
